// File: rtl/tw_horizontal_gen_pkg.sv
// Shared Goldilocks-field definitions for the twiddle ROM, its generators and the butterflies.
package tw_horizontal_gen_pkg;

    localparam int          DW           = 64;
    localparam logic [63:0] GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_HI   = 2'd1;
    localparam logic [1:0] W_LO   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPUTE,
        S_EMIT_HI,
        S_EMIT_LO,
        S_DONE
    } state_t;

    // Any 64-bit word is below 2P, so one subtraction makes it canonical.
    function automatic logic [63:0] reduce_once(input logic [63:0] x);
        return (x >= GOLDILOCKS_P) ? (x - GOLDILOCKS_P) : x;
    endfunction

endpackage

// File: rtl/goldilocks_mulmod.sv
// Two-stage pipelined a*b mod p for canonical operands: full product, then limb-based reduction.
module goldilocks_mulmod #(
    parameter int          DW = 64,
    parameter logic [DW-1:0] P  = 64'hFFFF_FFFF_0000_0001
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          vld_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          vld_o,
    output logic [DW-1:0] r_o
);

    logic [2*DW-1:0] prod_q;
    logic [DW-1:0]   r_q;
    logic            vld_p1_q;
    logic            vld_p2_q;

    // 2^64 = 2^32-1 and 2^96 = -1 (mod p), so x = lo + x2*(2^32-1) - x3 lies in (-p, 2p).
    function automatic logic [DW-1:0] reduce128(input logic [2*DW-1:0] x);
        logic [DW-1:0]          eps_prod;
        logic signed [DW+3:0]   v;
        logic signed [DW+3:0]   p_s;
        eps_prod = {32'b0, x[95:64]} * 64'h0000_0000_FFFF_FFFF;
        p_s      = $signed({4'b0, P});
        v        = $signed({4'b0, x[63:0]}) + $signed({4'b0, eps_prod})
                 - $signed({36'b0, x[127:96]});
        if (v < 0)
            v = v + p_s;
        else if (v >= p_s)
            v = v - p_s;
        return v[DW-1:0];
    endfunction

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_i;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge CLK) begin
        prod_q <= {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        r_q    <= reduce128(prod_q);
    end

    assign vld_o = vld_p2_q;
    assign r_o   = r_q;

endmodule

// File: rtl/tw_horizontal_gen.sv
// Computes powers 0..3 of two Goldilocks bases and streams them as upper/lower 4-word bursts.
module tw_horizontal_gen
    import tw_horizontal_gen_pkg::*;
#(
    parameter int            DW   = 64,
    parameter logic [DW-1:0] P    = 64'hFFFF_FFFF_0000_0001,
    parameter int            N_PW = 4
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] base_hi,
    input  logic [DW-1:0] base_lo,
    output logic          busy,
    output logic          done,
    output logic [1:0]    ROM3_w,
    output logic [DW-1:0] horizontal_tf_out
);

    localparam int CNT_W = 3;
    localparam int IDX_W = $clog2(N_PW);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       w_q;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    pw_hi_q [N_PW];
    logic [DW-1:0]    pw_lo_q [N_PW];

    logic             mul_issue;
    logic [DW-1:0]    mul_a;
    logic [DW-1:0]    mul_b;
    logic             mul_vld;
    logic [DW-1:0]    mul_r;
    logic [IDX_W-1:0] nxt_idx;

    // Squares issue at c0/c1; the cubes at c2/c3 take the square straight off the multiplier output.
    always_comb begin
        mul_issue = (state_q == S_COMPUTE) && (cnt_q < 3'd4);
        mul_a     = cnt_q[0] ? pw_lo_q[1] : pw_hi_q[1];
        mul_b     = cnt_q[0] ? pw_lo_q[1] : pw_hi_q[1];
        if (cnt_q[1])
            mul_a = mul_r;
        nxt_idx   = cnt_q[IDX_W-1:0] + IDX_W'(1);
    end

    goldilocks_mulmod #(
        .DW (DW),
        .P  (P)
    ) u_mulmod (
        .CLK   (CLK),
        .rst_n (rst_n),
        .vld_i (mul_issue),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .vld_o (mul_vld),
        .r_o   (mul_r)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= W_NONE;
            data_q  <= '0;
            for (int i = 0; i < N_PW; i++) begin
                pw_hi_q[i] <= '0;
                pw_lo_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pw_hi_q[0] <= DW'(1);
                        pw_lo_q[0] <= DW'(1);
                        pw_hi_q[1] <= reduce_once(base_hi);
                        pw_lo_q[1] <= reduce_once(base_lo);
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (mul_vld) begin
                        case (cnt_q)
                            3'd2:    pw_hi_q[2] <= mul_r;
                            3'd3:    pw_lo_q[2] <= mul_r;
                            3'd4:    pw_hi_q[3] <= mul_r;
                            3'd5:    pw_lo_q[3] <= mul_r;
                            default: ;
                        endcase
                    end
                    if (cnt_q == 3'd5) begin
                        cnt_q   <= '0;
                        w_q     <= W_HI;
                        data_q  <= pw_hi_q[0];
                        state_q <= S_EMIT_HI;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_EMIT_HI: begin
                    // The lower burst must follow with no gap: the ROM index clears on an idle cycle.
                    if (cnt_q == CNT_W'(N_PW - 1)) begin
                        cnt_q   <= '0;
                        w_q     <= W_LO;
                        data_q  <= pw_lo_q[0];
                        state_q <= S_EMIT_LO;
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        data_q <= pw_hi_q[nxt_idx];
                    end
                end
                S_EMIT_LO: begin
                    if (cnt_q == CNT_W'(N_PW - 1)) begin
                        cnt_q   <= '0;
                        w_q     <= W_NONE;
                        data_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        data_q <= pw_lo_q[nxt_idx];
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign ROM3_w            = w_q;
    assign horizontal_tf_out = data_q;

endmodule

// File: tb/tb_tw_horizontal_gen.sv
// Directed and randomized checks of the twiddle power generator against an arithmetic model.
module tb_tw_horizontal_gen;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] base_hi = '0;
    logic [63:0] base_lo = '0;
    logic        busy;
    logic        done;
    logic [1:0]  ROM3_w;
    logic [63:0] horizontal_tf_out;

    int total = 0;
    int bad   = 0;

    logic [63:0] rom_hi [4];
    logic [63:0] rom_lo [4];
    int          rom_idx;

    tw_horizontal_gen dut (
        .CLK               (CLK),
        .rst_n             (rst_n),
        .start             (start),
        .base_hi           (base_hi),
        .base_lo           (base_lo),
        .busy              (busy),
        .done              (done),
        .ROM3_w            (ROM3_w),
        .horizontal_tf_out (horizontal_tf_out)
    );

    always #5 CLK = ~CLK;

    // Stage-0 ROM write port: shared index wraps 3->0, clears on any idle cycle.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rom_idx <= 0;
        end else if (ROM3_w == 2'd0) begin
            rom_idx <= 0;
        end else begin
            if (ROM3_w == 2'd1) rom_hi[rom_idx] <= horizontal_tf_out;
            else                rom_lo[rom_idx] <= horizontal_tf_out;
            rom_idx <= (rom_idx + 1) % 4;
        end
    end

    function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] t;
        t = {64'b0, a} * {64'b0, b};
        t = t % {64'b0, P};
        return t[63:0];
    endfunction

    task automatic model(input logic [63:0] bse, output logic [63:0] e [4]);
        logic [63:0] b;
        b = bse % P;
        e[0] = 64'd1;
        for (int i = 1; i < 4; i++) e[i] = mm(e[i-1], b);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] bh, input logic [63:0] bl);
        @(negedge CLK);
        start   = 1'b1;
        base_hi = bh;
        base_lo = bl;
        @(posedge CLK);
        #1;
        start   = 1'b0;
        base_hi = {$urandom, $urandom};
        base_lo = {$urandom, $urandom};
    endtask

    // Called at the sample point just after the accepting edge; k counts cycles from there.
    task automatic check_run(input logic [63:0] eh [4], input logic [63:0] el [4],
                             input int rst_at, input bit inject);
        logic [1:0]  ew;
        logic [63:0] ed;
        for (int k = 1; k <= 16; k++) begin
            ew = (k >= 7 && k <= 10) ? 2'd1 : (k >= 11 && k <= 14) ? 2'd2 : 2'd0;
            ed = (k >= 7 && k <= 10) ? eh[k-7] : (k >= 11 && k <= 14) ? el[k-11] : 64'd0;
            chk($sformatf("busy@%0d", k), {63'b0, busy}, {63'b0, (k <= 15)});
            chk($sformatf("done@%0d", k), {63'b0, done}, {63'b0, (k == 15)});
            chk($sformatf("w@%0d", k), {62'b0, ROM3_w}, {62'b0, ew});
            chk($sformatf("data@%0d", k), horizontal_tf_out, ed);
            if (inject && (k == 3 || k == 15)) begin
                start   = 1'b1;
                base_hi = {$urandom, $urandom};
                base_lo = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_w", {62'b0, ROM3_w}, 64'd0);
                chk("rst_data", horizontal_tf_out, 64'd0);
                chk("rst_busy", {63'b0, busy}, 64'd0);
                chk("rst_done", {63'b0, done}, 64'd0);
                @(negedge CLK);
                rst_n = 1'b1;
                return;
            end
            if (k < 16) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic chk_rom(input logic [63:0] eh [4], input logic [63:0] el [4]);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rom_hi[%0d]", i), rom_hi[i], eh[i]);
            chk($sformatf("rom_lo[%0d]", i), rom_lo[i], el[i]);
        end
    endtask

    logic [63:0] eh [4];
    logic [63:0] el [4];
    logic [63:0] bh, bl;

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_w", {62'b0, ROM3_w}, 64'd0);
        chk("reset_data", horizontal_tf_out, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        // Basic powers
        eh = '{64'd1, 64'd2, 64'd4, 64'd8};
        el = '{64'd1, 64'd3, 64'd9, 64'd27};
        do_start(64'd2, 64'd3);
        check_run(eh, el, 0, 1'b0);
        chk_rom(eh, el);

        // Reduction path
        eh = '{64'd1, 64'h1_0000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000};
        el = '{64'd1, P - 64'd1, 64'd1, P - 64'd1};
        do_start(64'h1_0000_0000, P - 64'd1);
        check_run(eh, el, 0, 1'b0);

        // Non-canonical and zero bases
        eh = '{64'd1, 64'd2, 64'd4, 64'd8};
        el = '{64'd1, 64'd0, 64'd0, 64'd0};
        do_start(P + 64'd2, 64'd0);
        check_run(eh, el, 0, 1'b0);

        // Starts while busy (COMPUTE and DONE) are ignored
        model(64'd5, eh);
        model(64'd7, el);
        do_start(64'd5, 64'd7);
        check_run(eh, el, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            chk("idle_w", {62'b0, ROM3_w}, 64'd0);
            chk("idle_busy", {63'b0, busy}, 64'd0);
        end

        // Reset mid EMIT_HI, then a full rerun
        model(64'd11, eh);
        model(64'd13, el);
        do_start(64'd11, 64'd13);
        check_run(eh, el, 9, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        chk("post_rst_w", {62'b0, ROM3_w}, 64'd0);
        chk("post_rst_busy", {63'b0, busy}, 64'd0);
        model(64'h1234_5678_9ABC_DEF0, eh);
        model(P + 64'd100, el);
        do_start(64'h1234_5678_9ABC_DEF0, P + 64'd100);
        check_run(eh, el, 0, 1'b0);

        // Back-to-back: second start at the first legal edge
        model(64'd3, eh);
        model(64'd6, el);
        do_start(64'd3, 64'd6);
        check_run(eh, el, 0, 1'b0);
        bl = {$urandom, $urandom};
        model(64'hFFEF_FFFE_FFFF_FFF1, eh);
        model(bl, el);
        do_start(64'hFFEF_FFFE_FFFF_FFF1, bl);
        check_run(eh, el, 0, 1'b0);
        chk_rom(eh, el);

        // Randomized bases, including some just above P
        for (int r = 0; r < 8; r++) begin
            bh = {$urandom, $urandom};
            bl = {$urandom, $urandom};
            if (r % 3 == 1) bh = P + 64'($urandom_range(0, 1000));
            if (r % 4 == 2) bl = P - 64'($urandom_range(0, 1000));
            model(bh, eh);
            model(bl, el);
            do_start(bh, bl);
            check_run(eh, el, 0, 1'b0);
            chk_rom(eh, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tw_horizontal_gen.md
# tw_horizontal_gen

Upstream twiddle generator for the 64-point twiddle ROM of the radix-16 NTT datapath. It takes two base twiddles over the Goldilocks field, p = 2^64 − 2^32 + 1, and computes their powers 0..3. It then streams the eight 64-bit results into the ROM's stage-0 horizontal write port as two contiguous 4-cycle bursts: the upper-half burst first, then the lower-half burst.

## Interface
Parameters:
- DW, 64: field word width.
- P, 64'hFFFF_FFFF_0000_0001: field modulus.
- N_PW, 4: powers per half, equal to ROM stage-0 depth.

Ports:
- CLK  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_hi  in  DW  base for upper-half entries; captured on accepted start
- base_lo  in  DW  base for lower-half entries; captured on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse after the last write
- ROM3_w  out  2  0 = no write, 1 = upper-half write, 2 = lower-half write
- horizontal_tf_out  out  DW  write data, valid when ROM3_w ≠ 0

## Operation
- State machine: IDLE → COMPUTE → EMIT_HI → EMIT_LO → DONE → IDLE.
- IDLE:
  - start=1 captures both bases and enters COMPUTE.
  - A base ≥ P is reduced once by subtracting P on capture.
- Power buffers: pw_hi[0..3] and pw_lo[0..3]. On capture, pw_x[0]=1 and pw_x[1]=base_x.
- COMPUTE: one shared multiplier, fixed latency 2, one issue per cycle. Issue schedule by COMPUTE cycle c:
  - c0: hi·hi
  - c1: lo·lo
  - c2: pw_hi[2]·hi (result from c0 is available here)
  - c3: pw_lo[2]·lo
  - pw_hi[3] written at c4, pw_lo[3] written at c5.
  - Exit to EMIT_HI after c5. COMPUTE is exactly 6 cycles.
- EMIT_HI: 4 cycles, ROM3_w=1, data pw_hi[0], [1], [2], [3] in order.
- EMIT_LO: 4 cycles, ROM3_w=2, data pw_lo[0..3] in order. It follows EMIT_HI with no gap, because the ROM's write index wraps 3→0 and clears on any idle cycle.
- DONE: 1 cycle; done=1, ROM3_w=0, then IDLE.
- start outside IDLE is ignored, including start in the DONE cycle.
- Multiplication is a·b mod P with both operands canonical (< P) and the result canonical. Reduction of the 128-bit product x = {x3, x2, x1, x0} (32-bit limbs):
  - r = {x1, x0} − x3 + x2·(2^32 − 1) mod P
  - Apply conditional ±P corrections so the result is < P.
- Outputs outside EMIT states: ROM3_w=0 and horizontal_tf_out=0.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, ROM3_w=0, horizontal_tf_out=0
  - power buffers = 0
  - multiplier pipeline valid bits = 0
- All outputs are registered.
- For start accepted at edge T:
  - busy=1 at T+1
  - COMPUTE at T+1..T+6
  - ROM3_w=1 at T+7..T+10
  - ROM3_w=2 at T+11..T+14
  - done=1 and busy=1 at T+15; busy=0 at T+16
- Total 15 cycles from start to done, fixed and independent of data.
- Next start is accepted at T+16 at the earliest.
- Reset asserted mid-operation takes effect immediately (asynchronous):
  - outputs and state return to reset values
  - no partial burst is continued after release
  - the ROM keeps whatever half-written data it received, and the controller must rerun.
- Changing base_hi/base_lo after capture has no effect.

## Structure
- Shared package, with the twiddle ROM and butterflies:
  - GOLDILOCKS_P and the DW localparam
  - ROM3_w encodings (W_NONE=0, W_HI=1, W_LO=2)
  - state enum
- Sub-module goldilocks_mulmod: 2-stage pipelined a·b mod P with valid in/out. Stage 1 is the 64×64 product; stage 2 is the reduction. It is reusable by the butterfly units.

## Test plan
- Basic powers: base_hi=2, base_lo=3, start → ROM3_w=1 data 1,2,4,8 at T+7..T+10; ROM3_w=2 data 1,3,9,27 at T+11..T+14; done at T+15.
- Reduction path: base_hi=2^32 → 1, 0x1_0000_0000, 0xFFFF_FFFF, 0xFFFF_FFFF_0000_0000. base_lo=P−1 → 1, P−1, 1, P−1.
- Non-canonical base: base_hi=P+2 → 1,2,4,8. base_lo=0 → 1,0,0,0.
- Busy rejection: second start at T+3 with different bases → output unchanged from the first run; no second burst.
- Reset at T+9 (mid EMIT_HI) → ROM3_w=0, data=0, busy=0 immediately. A new start after release gives a full, correct 15-cycle sequence.
- Back-to-back: start at T+16 → second burst begins at T+23. A ROM model loaded from the generator's output matches its reset constants (base_hi=0xFFEF_FFFE_FFFF_FFF1 gives the BC=64 upper word).
